// File: rtl/kpn_pkg.sv
// Shared KPN fabric definitions: operand/token widths, default channel depth, token type.
package kpn_pkg;

  localparam int unsigned KPN_OPERAND_WIDTH      = 16;
  localparam int unsigned KPN_TOKEN_WIDTH        = 32;
  localparam int unsigned KPN_FIFO_DEPTH_DEFAULT = 8;

  typedef logic [KPN_TOKEN_WIDTH-1:0] kpn_token_t;

endpackage

// File: rtl/kpn_fifo_mem.sv
// Token storage for a KPN channel: one synchronous write port and one registered read port.
module kpn_fifo_mem
  import kpn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KPN_TOKEN_WIDTH,
  parameter int unsigned DEPTH      = KPN_FIFO_DEPTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-address read and write on one edge returns the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/kpn_fifo_channel.sv
// Bounded blocking FIFO channel for KPN tokens; sticky error flags when KPN_FIFO_ERR_FLAGS_EN
// is defined.
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KPN_TOKEN_WIDTH,
  parameter int unsigned DEPTH      = KPN_FIFO_DEPTH_DEFAULT,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    count
`ifdef KPN_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [PTR_WIDTH:0] FullCount = (PTR_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_WIDTH:0]   r_count;
  logic                 r_data_valid;
  logic                 w_full, w_empty;
  logic                 w_rd_acc, w_wr_acc;

  assign w_full  = (r_count == FullCount);
  assign w_empty = (r_count == '0);

  // A read frees a slot on the same edge, so a write to a full channel is accepted with it.
  assign w_rd_acc = rd && !w_empty;
  assign w_wr_acc = wr && (!w_full || w_rd_acc);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  kpn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_wr_acc && reset_n),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_out)
  );

`ifdef KPN_FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign data_valid = r_data_valid;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Scoreboard bench for kpn_fifo_channel: driver pushes expected read data, monitor pops on
// data_valid.
module tb_kpn_fifo_channel;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] data_in = '0;
  logic        full, empty, data_valid;
  logic [31:0] data_out;
  logic [3:0]  count;
`ifdef KPN_FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif

  kpn_fifo_channel #(
    .DATA_WIDTH (32),
    .DEPTH      (Depth)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr),
    .data_in    (data_in),
    .full       (full),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
    .count      (count)
`ifdef KPN_FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] tok = 32'h0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: read latency is exactly one cycle, so every pushed token must show at this negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {31'b0, data_valid}, 32'd0);
        end else begin
          chk("read_data", data_out, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_valid", {31'b0, data_valid}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the following negedge with status checked against the model.
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    bit rd_acc, wr_acc;
    wr = w;
    data_in = d;
    rd = r;
    @(posedge clk);
    rd_acc = r && (model_q.size() > 0);
    wr_acc = w && ((model_q.size() < Depth) || rd_acc);
    if (rd_acc) exp_q.push_back(model_q.pop_front());
    if (wr_acc) model_q.push_back(d);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    chk("count", 32'(count), 32'(model_q.size()));
    chk("full", {31'b0, full}, {31'b0, model_q.size() == Depth});
    chk("empty", {31'b0, empty}, {31'b0, model_q.size() == 0});
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    wr = 1'b1;
    rd = 1'b1;
    data_in = 32'hDEAD_BEEF;
    @(posedge clk);
    model_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_full", {31'b0, full}, 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_valid", {31'b0, data_valid}, 32'd0);
`ifdef KPN_FIFO_ERR_FLAGS_EN
    chk("reset_overflow", {31'b0, overflow}, 32'd0);
    chk("reset_underflow", {31'b0, underflow}, 32'd0);
`endif
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Single token 3x2
    step(1'b1, 32'h0000_0006, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("data_out_hold", data_out, 32'h0000_0006);

    // Fill with 1..9; the 9th is refused
    for (int i = 1; i <= 9; i++) step(1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
`ifdef KPN_FIFO_ERR_FLAGS_EN
    chk("overflow", {31'b0, overflow}, 32'd1);
`endif

    // Simultaneous read/write while full
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    step(1'b1, 32'hFFFE_0001, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Read and write together on an empty channel: no fall-through
    step(1'b1, 32'h0000_1234, 1'b1);
    chk("empty_edge_valid", {31'b0, data_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
`ifdef KPN_FIFO_ERR_FLAGS_EN
    chk("underflow", {31'b0, underflow}, 32'd1);
`endif

    // Random traffic across pointer wraps
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), tok, 1'($urandom_range(0, 1)));
      tok++;
    end

    // Bring occupancy to 5, then reset mid-operation
    while (model_q.size() < 5) begin
      step(1'b1, tok, 1'b0);
      tok++;
    end
    while (model_q.size() > 5) step(1'b0, 32'h0, 1'b1);
    pulse_reset();
`ifdef KPN_FIFO_ERR_FLAGS_EN
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_underflow", {31'b0, underflow}, 32'd0);
`endif

    for (int i = 0; i < 30; i++) begin
      step(1'($urandom_range(0, 1)), 32'h0005_0000 + 32'(i), 1'($urandom_range(0, 1)));
    end
    while (model_q.size() > 0) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
